// File: rtl/id_pkg.sv
// Shared decode constants and micro-op layout for the decode/issue stage.
// Opcodes, funct codes, one-hot ALU bit positions and operand-select encodings.
package id_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2a;

  // One-hot ALU bit order {add,sub,slt,sltu,and,nor,or,xor,sll,srl,sra,lui}
  localparam int ALU_W    = 12;
  localparam int ALU_ADD  = 11;
  localparam int ALU_SUB  = 10;
  localparam int ALU_SLT  = 9;
  localparam int ALU_SLTU = 8;
  localparam int ALU_AND  = 7;
  localparam int ALU_NOR  = 6;
  localparam int ALU_OR   = 5;
  localparam int ALU_XOR  = 4;
  localparam int ALU_SLL  = 3;
  localparam int ALU_SRL  = 2;
  localparam int ALU_SRA  = 1;
  localparam int ALU_LUI  = 0;

  localparam int          SRC1_W  = 3;
  localparam logic [2:0]  SRC1_SA = 3'b100;
  localparam logic [2:0]  SRC1_PC = 3'b010;
  localparam logic [2:0]  SRC1_RS = 3'b001;

  localparam int          SRC2_W    = 4;
  localparam logic [3:0]  SRC2_ZIMM = 4'b1000;
  localparam logic [3:0]  SRC2_8    = 4'b0100;
  localparam logic [3:0]  SRC2_SIMM = 4'b0010;
  localparam logic [3:0]  SRC2_RT   = 4'b0001;

  localparam int REG_W  = 5;
  localparam int WEN_W  = 4;

  typedef struct packed {
    logic [ALU_W-1:0]  alu_op;
    logic [SRC1_W-1:0] src1_sel;
    logic [SRC2_W-1:0] src2_sel;
    logic              mem_en;
    logic [WEN_W-1:0]  mem_wen;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic              wb_sel_load;
    logic              illegal;
  } uop_t;

endpackage

// File: rtl/id_bypass_mux.sv
// Priority operand forwarding: lowest-index matching bypass source wins, $0 reads 0.
// Purely combinational; flags when the winning source is a load whose data is not ready.
module id_bypass_mux
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BYP = 3
) (
  input  logic [REG_W-1:0]         reg_i,
  input  logic [DATA_W-1:0]        rf_rdata_i,
  input  logic [NUM_BYP-1:0]       byp_we_i,
  input  logic [NUM_BYP-1:0]       byp_is_load_i,
  input  logic [REG_W*NUM_BYP-1:0] byp_waddr_i,
  input  logic [DATA_W*NUM_BYP-1:0] byp_wdata_i,
  output logic [DATA_W-1:0]        data_o,
  output logic                     load_pend_o
);

  always_comb begin
    data_o      = rf_rdata_i;
    load_pend_o = 1'b0;
    // Walk from the oldest source down so the youngest match is applied last.
    for (int i = NUM_BYP - 1; i >= 0; i--) begin
      if (byp_we_i[i] && (byp_waddr_i[REG_W*i +: REG_W] == reg_i)) begin
        data_o      = byp_wdata_i[DATA_W*i +: DATA_W];
        load_pend_o = byp_is_load_i[i];
      end
    end
    if (reg_i == '0) begin
      data_o      = '0;
      load_pend_o = 1'b0;
    end
  end

endmodule

// File: rtl/id_issue_stage.sv
// MIPS decode/issue stage: one decode register plus one registered micro-op towards EX.
// 1 cycle decode-to-issue; holds on load-use hazard or !out_ready, flush kills both stages.
module id_issue_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int NUM_BYP = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               in_inst,
  input  logic                      flush,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [DATA_W-1:0]         rf_rdata1,
  input  logic [DATA_W-1:0]         rf_rdata2,
  input  logic [NUM_BYP-1:0]        byp_we,
  input  logic [NUM_BYP-1:0]        byp_is_load,
  input  logic [5*NUM_BYP-1:0]      byp_waddr,
  input  logic [DATA_W*NUM_BYP-1:0] byp_wdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_pc,
  output logic [31:0]               out_inst,
  output logic [11:0]               out_alu_op,
  output logic [2:0]                out_src1_sel,
  output logic [3:0]                out_src2_sel,
  output logic                      out_mem_en,
  output logic [3:0]                out_mem_wen,
  output logic                      out_rf_we,
  output logic [4:0]                out_rf_waddr,
  output logic                      out_wb_sel_load,
  output logic                      out_illegal,
  output logic [DATA_W-1:0]         out_rdata1,
  output logic [DATA_W-1:0]         out_rdata2,
  output logic                      br_taken,
  output logic [31:0]               br_target,
  output logic                      stall_load
);

  logic              d_valid_q, d_valid_d;
  logic [31:0]       d_pc_q, d_inst_q;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_pc_q, out_inst_q;
  uop_t              out_uop_q;
  logic [DATA_W-1:0] out_rdata1_q, out_rdata2_q;

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [15:0]       imm;
  uop_t              uop;
  logic              use_rs, use_rt;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              rs_pend, rt_pend;
  logic              hazard, issue, accept, br_cond;
  logic [31:0]       pc_plus4;

  assign opcode    = d_inst_q[31:26];
  assign rs        = d_inst_q[25:21];
  assign rt        = d_inst_q[20:16];
  assign rd        = d_inst_q[15:11];
  assign funct     = d_inst_q[5:0];
  assign imm       = d_inst_q[15:0];
  assign rf_raddr1 = rs;
  assign rf_raddr2 = rt;

  id_bypass_mux #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) u_byp_rs (
    .reg_i(rs), .rf_rdata_i(rf_rdata1), .byp_we_i(byp_we), .byp_is_load_i(byp_is_load),
    .byp_waddr_i(byp_waddr), .byp_wdata_i(byp_wdata), .data_o(rs_fwd), .load_pend_o(rs_pend)
  );

  id_bypass_mux #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) u_byp_rt (
    .reg_i(rt), .rf_rdata_i(rf_rdata2), .byp_we_i(byp_we), .byp_is_load_i(byp_is_load),
    .byp_waddr_i(byp_waddr), .byp_wdata_i(byp_wdata), .data_o(rt_fwd), .load_pend_o(rt_pend)
  );

  always_comb begin
    uop    = '0;
    use_rs = 1'b0;
    use_rt = 1'b0;
    case (opcode)
      OP_SPECIAL: begin
        uop.src1_sel = SRC1_RS;
        uop.src2_sel = SRC2_RT;
        uop.rf_we    = 1'b1;
        uop.rf_waddr = rd;
        use_rs       = 1'b1;
        use_rt       = 1'b1;
        case (funct)
          FN_ADDU: uop.alu_op[ALU_ADD] = 1'b1;
          FN_SUBU: uop.alu_op[ALU_SUB] = 1'b1;
          FN_AND:  uop.alu_op[ALU_AND] = 1'b1;
          FN_OR:   uop.alu_op[ALU_OR]  = 1'b1;
          FN_SLT:  uop.alu_op[ALU_SLT] = 1'b1;
          FN_SLL: begin
            uop.alu_op[ALU_SLL] = 1'b1;
            uop.src1_sel        = SRC1_SA;
            use_rs              = 1'b0;
          end
          FN_JR: begin
            uop    = '0;
            use_rt = 1'b0;
          end
          default: begin
            uop         = '0;
            uop.illegal = 1'b1;
            use_rs      = 1'b0;
            use_rt      = 1'b0;
          end
        endcase
      end
      OP_ADDIU, OP_LW: begin
        uop.alu_op[ALU_ADD] = 1'b1;
        uop.src1_sel        = SRC1_RS;
        uop.src2_sel        = SRC2_SIMM;
        uop.rf_we           = 1'b1;
        uop.rf_waddr        = rt;
        uop.mem_en          = (opcode == OP_LW);
        uop.wb_sel_load     = (opcode == OP_LW);
        use_rs              = 1'b1;
      end
      OP_ORI: begin
        uop.alu_op[ALU_OR] = 1'b1;
        uop.src1_sel       = SRC1_RS;
        uop.src2_sel       = SRC2_ZIMM;
        uop.rf_we          = 1'b1;
        uop.rf_waddr       = rt;
        use_rs             = 1'b1;
      end
      OP_LUI: begin
        uop.alu_op[ALU_LUI] = 1'b1;
        uop.src2_sel        = SRC2_ZIMM;
        uop.rf_we           = 1'b1;
        uop.rf_waddr        = rt;
      end
      OP_SW: begin
        uop.alu_op[ALU_ADD] = 1'b1;
        uop.src1_sel        = SRC1_RS;
        uop.src2_sel        = SRC2_SIMM;
        uop.mem_en          = 1'b1;
        uop.mem_wen         = 4'hf;
        use_rs              = 1'b1;
        use_rt              = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      OP_J: ;
      OP_JAL: begin
        uop.alu_op[ALU_ADD] = 1'b1;
        uop.src1_sel        = SRC1_PC;
        uop.src2_sel        = SRC2_8;
        uop.rf_we           = 1'b1;
        uop.rf_waddr        = 5'd31;
      end
      default: uop.illegal = 1'b1;
    endcase
  end

  assign pc_plus4 = d_pc_q + 32'd4;

  always_comb begin
    br_cond   = 1'b0;
    br_target = pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
    case (opcode)
      OP_BEQ: br_cond = (rs_fwd == rt_fwd);
      OP_BNE: br_cond = (rs_fwd != rt_fwd);
      OP_J, OP_JAL: begin
        br_cond   = 1'b1;
        br_target = {pc_plus4[31:28], d_inst_q[25:0], 2'b00};
      end
      OP_SPECIAL: begin
        if (funct == FN_JR) begin
          br_cond   = 1'b1;
          br_target = 32'(rs_fwd);
        end
      end
      default: ;
    endcase
  end

  assign hazard     = (use_rs && rs_pend) || (use_rt && rt_pend);
  assign issue      = d_valid_q && !hazard && !flush && (!out_valid_q || out_ready);
  assign in_ready   = !flush && (!d_valid_q || issue);
  assign accept     = in_valid && in_ready;
  assign stall_load = d_valid_q && hazard;
  // Gating with issue yields exactly one redirect pulse per taken branch.
  assign br_taken   = issue && br_cond;

  always_comb begin
    d_valid_d = d_valid_q;
    if (flush)       d_valid_d = 1'b0;
    else if (accept) d_valid_d = 1'b1;
    else if (issue)  d_valid_d = 1'b0;

    out_valid_d = out_valid_q;
    if (flush)          out_valid_d = 1'b0;
    else if (issue)     out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_valid_q    <= 1'b0;
      d_pc_q       <= '0;
      d_inst_q     <= '0;
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= '0;
      out_uop_q    <= '0;
      out_rdata1_q <= '0;
      out_rdata2_q <= '0;
    end else begin
      d_valid_q   <= d_valid_d;
      out_valid_q <= out_valid_d;
      if (accept) begin
        d_pc_q   <= in_pc;
        d_inst_q <= in_inst;
      end
      if (issue) begin
        out_pc_q     <= d_pc_q;
        out_inst_q   <= d_inst_q;
        out_uop_q    <= uop;
        out_rdata1_q <= rs_fwd;
        out_rdata2_q <= rt_fwd;
      end
    end
  end

  assign out_valid       = out_valid_q;
  assign out_pc          = out_pc_q;
  assign out_inst        = out_inst_q;
  assign out_alu_op      = out_uop_q.alu_op;
  assign out_src1_sel    = out_uop_q.src1_sel;
  assign out_src2_sel    = out_uop_q.src2_sel;
  assign out_mem_en      = out_uop_q.mem_en;
  assign out_mem_wen     = out_uop_q.mem_wen;
  assign out_rf_we       = out_uop_q.rf_we;
  assign out_rf_waddr    = out_uop_q.rf_waddr;
  assign out_wb_sel_load = out_uop_q.wb_sel_load;
  assign out_illegal     = out_uop_q.illegal;
  assign out_rdata1      = out_rdata1_q;
  assign out_rdata2      = out_rdata2_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Scoreboard bench for id_issue_stage: directed vectors push expected micro-ops,
// a negedge monitor pops and compares on every EX transfer and every branch pulse.
module tb_id_issue_stage;

  localparam int DATA_W  = 32;
  localparam int NUM_BYP = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]               in_pc, in_inst, out_pc, out_inst, br_target;
  logic [4:0]                rf_raddr1, rf_raddr2, out_rf_waddr;
  logic [DATA_W-1:0]         rf_rdata1, rf_rdata2, out_rdata1, out_rdata2, rf_val;
  logic [NUM_BYP-1:0]        byp_we, byp_is_load;
  logic [5*NUM_BYP-1:0]      byp_waddr;
  logic [DATA_W*NUM_BYP-1:0] byp_wdata;
  logic [11:0]               out_alu_op;
  logic [2:0]                out_src1_sel;
  logic [3:0]                out_src2_sel, out_mem_wen;
  logic                      out_mem_en, out_rf_we, out_wb_sel_load, out_illegal;
  logic                      br_taken, stall_load;

  typedef struct packed {
    logic [31:0] pc, inst;
    logic [11:0] alu;
    logic [2:0]  s1;
    logic [3:0]  s2;
    logic        mem_en;
    logic [3:0]  wen;
    logic        rf_we;
    logic [4:0]  wa;
    logic        wb;
    logic        ill;
    logic [31:0] r1, r2;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] brq[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          br_pulses = 0;

  assign rf_rdata1 = rf_val;
  assign rf_rdata2 = rf_val;

  always #5 clk = ~clk;

  id_issue_stage #(.DATA_W(DATA_W), .NUM_BYP(NUM_BYP)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_inst(in_inst), .flush(flush), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .byp_we(byp_we), .byp_is_load(byp_is_load),
    .byp_waddr(byp_waddr), .byp_wdata(byp_wdata), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_alu_op(out_alu_op), .out_src1_sel(out_src1_sel),
    .out_src2_sel(out_src2_sel), .out_mem_en(out_mem_en), .out_mem_wen(out_mem_wen),
    .out_rf_we(out_rf_we), .out_rf_waddr(out_rf_waddr), .out_wb_sel_load(out_wb_sel_load),
    .out_illegal(out_illegal), .out_rdata1(out_rdata1), .out_rdata2(out_rdata2),
    .br_taken(br_taken), .br_target(br_target), .stall_load(stall_load)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, inst, input logic [11:0] alu,
                              input logic [2:0] s1, input logic [3:0] s2, input logic mem_en,
                              input logic [3:0] wen, input logic rf_we, input logic [4:0] wa,
                              input logic wb, ill, input logic [31:0] r1, r2);
    exp_t e;
    e = '{pc, inst, alu, s1, s2, mem_en, wen, rf_we, wa, wb, ill, r1, r2};
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_issue: got pc %h expected none", out_pc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("uop_pc", out_pc, mon_e.pc);
          chk("uop_inst", out_inst, mon_e.inst);
          chk("uop_alu", {20'h0, out_alu_op}, {20'h0, mon_e.alu});
          chk("uop_sel", {25'h0, out_src1_sel, out_src2_sel}, {25'h0, mon_e.s1, mon_e.s2});
          chk("uop_mem", {26'h0, out_mem_en, out_mem_wen, out_wb_sel_load},
              {26'h0, mon_e.mem_en, mon_e.wen, mon_e.wb});
          chk("uop_rf", {26'h0, out_rf_we, out_rf_waddr}, {26'h0, mon_e.rf_we, mon_e.wa});
          chk("uop_illegal", {31'h0, out_illegal}, {31'h0, mon_e.ill});
          chk("uop_rdata1", out_rdata1, mon_e.r1);
          chk("uop_rdata2", out_rdata2, mon_e.r2);
        end
      end
      if (br_taken) begin
        br_pulses++;
        if (brq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_br: got target %h expected no pulse", br_target);
        end else chk("br_target", br_target, brq.pop_front());
      end
    end
  end

  task automatic set_byp(input int i, input logic we, ld, input logic [4:0] a,
                         input logic [31:0] d);
    byp_we[i]             = we;
    byp_is_load[i]        = ld;
    byp_waddr[5*i +: 5]   = a;
    byp_wdata[32*i +: 32] = d;
  endtask

  task automatic clr_byp();
    for (int i = 0; i < NUM_BYP; i++) set_byp(i, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic send(input logic [31:0] pc, inst);
    in_valid = 1'b1;
    in_pc    = pc;
    in_inst  = inst;
    for (int k = 0; k <= 50; k++) begin
      @(negedge clk);
      if (in_ready) break;
      if (k == 50) begin
        tests++; fails++;
        $display("FAIL send_timeout: got in_ready 0 expected 1 (pc %h)", pc);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k <= 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && brq.size() == 0 && !out_valid) break;
      if (k == 100) begin
        tests++; fails++;
        $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0; flush = 1'b0;
    out_ready = 1'b1; rf_val = 32'hC;
    byp_we = '0; byp_is_load = '0; byp_waddr = '0; byp_wdata = '0;
    #1 rst = 1'b0;
    #3;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_br_stall", {30'h0, br_taken, stall_load}, 32'h0);
    chk("rst_raddr1", {27'h0, rf_raddr1}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    cyc();
    rst = 1'b1;

    // Back-to-back: addiu $2,$0,5 then ori $3,$2,1 forwarded from byp0
    clr_byp(); set_byp(0, 1'b1, 1'b0, 5'd2, 32'd5);
    exp_q.push_back(mk(32'h100, 32'h24020005, 12'h800, 3'b001, 4'b0010, 0, 4'h0, 1, 5'd2, 0, 0, 32'h0, 32'h5));
    exp_q.push_back(mk(32'h104, 32'h34430001, 12'h020, 3'b001, 4'b1000, 0, 4'h0, 1, 5'd3, 0, 0, 32'h5, 32'hC));
    send(32'h100, 32'h24020005);
    send(32'h104, 32'h34430001);
    @(negedge clk);
    chk("b2b_first", {out_valid, out_pc[30:0]}, 32'h8000_0100);
    cyc(); @(negedge clk);
    chk("b2b_second", {out_valid, out_pc[30:0]}, 32'h8000_0104);
    drain();

    // Priority: byp0 beats byp1 beats rf; $0 ignores bypasses
    clr_byp();
    set_byp(0, 1'b1, 1'b0, 5'd3, 32'hA);
    set_byp(1, 1'b1, 1'b0, 5'd3, 32'hB);
    set_byp(2, 1'b1, 1'b1, 5'd0, 32'h55);
    exp_q.push_back(mk(32'h110, 32'h00602021, 12'h800, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 0, 32'hA, 32'h0));
    send(32'h110, 32'h00602021); drain();
    set_byp(0, 1'b0, 1'b0, 5'd3, 32'hA);
    exp_q.push_back(mk(32'h114, 32'h00602021, 12'h800, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 0, 32'hB, 32'h0));
    send(32'h114, 32'h00602021); drain();
    set_byp(1, 1'b0, 1'b0, 5'd3, 32'hB);
    set_byp(0, 1'b1, 1'b1, 5'd0, 32'h77);
    exp_q.push_back(mk(32'h118, 32'h00602021, 12'h800, 3'b001, 4'b0001, 0, 4'h0, 1, 5'd4, 0, 0, 32'hC, 32'h0));
    send(32'h118, 32'h00602021); drain();

    // Load-use: sw $4,0($5) waits three cycles on a pending load of $4
    clr_byp(); set_byp(0, 1'b1, 1'b1, 5'd4, 32'h1111);
    exp_q.push_back(mk(32'h120, 32'hACA40000, 12'h800, 3'b001, 4'b0010, 1, 4'hF, 0, 5'd0, 0, 0, 32'hC, 32'h4444));
    send(32'h120, 32'hACA40000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("lu_stall", {29'h0, stall_load, in_ready, out_valid}, 32'h4);
      if (k == 0) chk("lu_raddr2", {27'h0, rf_raddr2}, 32'h4);
      cyc();
    end
    set_byp(0, 1'b1, 1'b0, 5'd4, 32'h4444);
    @(negedge clk);
    chk("lu_release", {31'h0, stall_load}, 32'h0);
    cyc(); @(negedge clk);
    chk("lu_issue", {31'h0, out_valid}, 32'h1);
    drain();

    // Branches: beq held by back-pressure pulses once; bne equal gives none
    clr_byp(); out_ready = 1'b0;
    exp_q.push_back(mk(32'h1FC, 32'h24020005, 12'h800, 3'b001, 4'b0010, 0, 4'h0, 1, 5'd2, 0, 0, 32'h0, 32'hC));
    exp_q.push_back(mk(32'h200, 32'h10E70003, 12'h000, 3'b000, 4'b0000, 0, 4'h0, 0, 5'd0, 0, 0, 32'hC, 32'hC));
    brq.push_back(32'h210);
    send(32'h1FC, 32'h24020005);
    send(32'h200, 32'h10E70003);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("br_held", {31'h0, br_taken}, 32'h0);
      cyc();
    end
    out_ready = 1'b1;
    drain();
    exp_q.push_back(mk(32'h204, 32'h14E70003, 12'h000, 3'b000, 4'b0000, 0, 4'h0, 0, 5'd0, 0, 0, 32'hC, 32'hC));
    send(32'h204, 32'h14E70003); drain();
    chk("br_pulses_beq_bne", br_pulses, 32'd1);
    exp_q.push_back(mk(32'h300, 32'h0C000040, 12'h800, 3'b010, 4'b0100, 0, 4'h0, 1, 5'd31, 0, 0, 32'h0, 32'h0));
    brq.push_back(32'h100);
    send(32'h300, 32'h0C000040); drain();
    set_byp(1, 1'b1, 1'b0, 5'd9, 32'h400);
    exp_q.push_back(mk(32'h304, 32'h01200008, 12'h000, 3'b000, 4'b0000, 0, 4'h0, 0, 5'd0, 0, 0, 32'h400, 32'h0));
    brq.push_back(32'h400);
    send(32'h304, 32'h01200008); drain();
    chk("br_pulses_total", br_pulses, 32'd3);

    // lw and an unsupported opcode back to back
    clr_byp();
    exp_q.push_back(mk(32'h308, 32'h8C060008, 12'h800, 3'b001, 4'b0010, 1, 4'h0, 1, 5'd6, 1, 0, 32'h0, 32'hC));
    exp_q.push_back(mk(32'h30C, 32'hFC000000, 12'h000, 3'b000, 4'b0000, 0, 4'h0, 0, 5'd0, 0, 1, 32'h0, 32'h0));
    send(32'h308, 32'h8C060008);
    send(32'h30C, 32'hFC000000);
    drain();

    // Back-pressure: 4-cycle stall on a continuous stream
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(32'h400 + 32'(4*k), 32'h24020010 + 32'(k), 12'h800, 3'b001, 4'b0010,
                         0, 4'h0, 1, 5'd2, 0, 0, 32'h0, 32'hC));
    send(32'h400, 32'h24020010);
    send(32'h404, 32'h24020011);
    in_valid = 1'b1; in_pc = 32'h408; in_inst = 32'h24020012;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("bp_frozen_pc", out_pc, 32'h400);
      chk("bp_frozen_inst", out_inst, 32'h24020010);
      chk("bp_hold", {30'h0, out_valid, in_ready}, 32'h2);
      cyc();
    end
    out_ready = 1'b1;
    send(32'h408, 32'h24020012);
    send(32'h40C, 32'h24020013);
    drain();

    // Flush with both stages full and a new input offered
    out_ready = 1'b0;
    send(32'h500, 32'h24020001);
    send(32'h504, 32'h10E70003);
    in_valid = 1'b1; in_pc = 32'h508; in_inst = 32'h24020002; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", {30'h0, in_ready, br_taken}, 32'h0);
    cyc();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("flush_cleared", {30'h0, out_valid, stall_load}, 32'h0);
      cyc();
    end

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send(32'h600, 32'h24020003);
    send(32'h604, 32'h24020004);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {29'h0, out_valid, br_taken, stall_load}, 32'h0);
    chk("arst_pc", out_pc, 32'h0);
    chk("arst_inst", out_inst, 32'h0);
    chk("arst_uop", {19'h0, out_rf_we, out_alu_op}, 32'h0);
    cyc();
    rst = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("arst_no_issue", {31'h0, out_valid}, 32'h0);
      cyc();
    end

    chk("queues_empty", 32'(exp_q.size() + brq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
